// File: rtl/fetch_exec_sequencer.sv
// Two-cycle fetch/execute controller for a 4-bit accumulator machine.
// It sits on an external program counter and a combinational instruction ROM.
module fetch_exec_sequencer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              run,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic [DATA_W+3:0] instr_data,
  output logic              PCload,
  output logic              PCinc,
  output logic [ADDR_W-1:0] load_in,
  output logic [DATA_W-1:0] acc,
  output logic [DATA_W+3:0] ir,
  output logic              busy,
  output logic              halted
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_SUBI = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_JZ   = 4'h5;
  localparam logic [3:0] OP_JNZ  = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W+3:0]   ir_q, ir_d;
  logic [3:0]          opcode;
  logic [DATA_W-1:0]   imm;
  logic [ADDR_W-1:0]   tgt;

  assign opcode     = ir_q[DATA_W+3:DATA_W];
  assign imm        = ir_q[DATA_W-1:0];
  assign tgt        = ADDR_W'(imm);
  assign instr_addr = pc_in;
  assign acc        = acc_q;
  assign ir         = ir_q;
  assign busy       = (state_q == S_FETCH) || (state_q == S_EXEC);
  assign halted     = (state_q == S_HALT);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ir_d    = ir_q;
    PCload  = 1'b0;
    PCinc   = 1'b0;
    load_in = '0;
    case (state_q)
      S_IDLE:  if (run) state_d = S_FETCH;
      S_FETCH: begin
        ir_d    = instr_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        // The instruction always retires; run only decides what follows it.
        state_d = run ? S_FETCH : S_IDLE;
        case (opcode)
          OP_HALT: state_d = S_HALT;
          OP_LDI: begin
            acc_d = imm;
            PCinc = 1'b1;
          end
          OP_ADDI: begin
            acc_d = acc_q + imm;
            PCinc = 1'b1;
          end
          OP_SUBI: begin
            acc_d = acc_q - imm;
            PCinc = 1'b1;
          end
          OP_JMP: begin
            PCload  = 1'b1;
            load_in = tgt;
          end
          OP_JZ: begin
            if (acc_q == '0) begin
              PCload  = 1'b1;
              load_in = tgt;
            end else begin
              PCinc = 1'b1;
            end
          end
          OP_JNZ: begin
            if (acc_q != '0) begin
              PCload  = 1'b1;
              load_in = tgt;
            end else begin
              PCinc = 1'b1;
            end
          end
          default: PCinc = 1'b1;  // NOP and every undefined opcode
        endcase
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

endmodule
